vram_cmd_sequencer: RTL and testbench

Executes decoded 32-bit GPU instructions against the framebuffer write port. Sits between `instruction_decoder` (consumes `o_instruction`/`o_instruction_ready`) and the VRAM. It queues instructions in a small FIFO, sequences multi-cycle pixel writes, and yields the memory port to VGA scanout whenever the display requests it.

---
 rtl/vram_cmd_sequencer.sv | 166 ++++++++++++++++
 tb/tb_vram_cmd_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_cmd_sequencer.sv
// Queues decoded GPU instructions and sequences pixel writes into VRAM, yielding to scanout.
// Optional FILL opcode, counter and state are compiled in with `define VRAM_FILL_EN.
module vram_cmd_sequencer #(
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [31:0]       i_instruction,
  input  logic              i_instruction_ready,
  input  logic              i_disp_req,
  output logic              o_busy,
  output logic              o_idle,
  output logic              o_overflow,
  output logic              o_illegal,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_data
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_SET   = 4'h1;
  localparam logic [3:0] OP_WRITE = 4'h2;
`ifdef VRAM_FILL_EN
  localparam logic [3:0] OP_FILL  = 4'h3;

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_WRITE, S_FILL} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_WRITE} state_t;
`endif

  state_t             state, state_d;
  logic [31:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count;
  logic [31:0]        cmd, cmd_d;
  logic [ADDR_W-1:0]  addr, addr_d;
  logic [ADDR_W-1:0]  mem_addr_d;
  logic [7:0]         mem_data_d;
  logic               we_d, illegal_d;
  logic               push, pop, full;
`ifdef VRAM_FILL_EN
  logic [15:0]        remaining, remaining_d;
`endif

  // Only the opcode, count and pixel fields are consumed; the rest is ignored.
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^cmd[27:8];

  assign full   = (count == CNT_W'(FIFO_DEPTH));
  assign push   = i_instruction_ready && !full;
  assign o_busy = full;
  assign o_idle = (state == S_IDLE) && (count == '0);

  // Instruction queue storage; no reset needed, validity tracked by count.
  always_ff @(posedge i_clk) begin
    if (push) fifo_mem[wr_ptr] <= i_instruction;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);
    end
  end

  // State and registered outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= S_IDLE;
      cmd        <= '0;
      addr       <= '0;
      o_mem_we   <= 1'b0;
      o_mem_addr <= '0;
      o_mem_data <= '0;
      o_illegal  <= 1'b0;
      o_overflow <= 1'b0;
`ifdef VRAM_FILL_EN
      remaining  <= '0;
`endif
    end else begin
      state      <= state_d;
      cmd        <= cmd_d;
      addr       <= addr_d;
      o_mem_we   <= we_d;
      o_mem_addr <= mem_addr_d;
      o_mem_data <= mem_data_d;
      o_illegal  <= illegal_d;
      o_overflow <= i_instruction_ready && full;
`ifdef VRAM_FILL_EN
      remaining  <= remaining_d;
`endif
    end
  end

  always_comb begin
    state_d    = state;
    cmd_d      = cmd;
    addr_d     = addr;
    we_d       = 1'b0;
    mem_addr_d = o_mem_addr;
    mem_data_d = o_mem_data;
    illegal_d  = 1'b0;
    pop        = 1'b0;
`ifdef VRAM_FILL_EN
    remaining_d = remaining;
`endif
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          cmd_d   = fifo_mem[rd_ptr];
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_IDLE;
        case (cmd[31:28])
          OP_NOP:   ;
          OP_SET:   addr_d = cmd[ADDR_W-1:0];
          OP_WRITE: state_d = S_WRITE;
`ifdef VRAM_FILL_EN
          OP_FILL: begin
            remaining_d = cmd[23:8];
            state_d     = S_FILL;
          end
`endif
          default:  illegal_d = 1'b1;
        endcase
      end
      S_WRITE: begin
        if (!i_disp_req) begin
          we_d       = 1'b1;
          mem_addr_d = addr;
          mem_data_d = cmd[7:0];
          addr_d     = addr + ADDR_W'(1);
          state_d    = S_IDLE;
        end
      end
`ifdef VRAM_FILL_EN
      // One pixel per uncontended cycle; remaining counts pixels after this one.
      S_FILL: begin
        if (!i_disp_req) begin
          we_d       = 1'b1;
          mem_addr_d = addr;
          mem_data_d = cmd[7:0];
          addr_d     = addr + ADDR_W'(1);
          if (remaining == '0) state_d = S_IDLE;
          else                 remaining_d = remaining - 16'd1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_vram_cmd_sequencer.sv
// Self-checking bench for vram_cmd_sequencer: per-cycle reference model plus directed literal checks.
module tb_vram_cmd_sequencer;

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned DEPTH  = 4;
  localparam int M_READY  = 0;
  localparam int M_DECODE = 1;
  localparam int M_PIXELS = 2;

  logic              clk;
  logic              rst_n;
  logic [31:0]       instr;
  logic              ready;
  logic              disp;
  logic              o_busy, o_idle, o_overflow, o_illegal, o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [7:0]        o_mem_data;

  int checks = 0;
  int errors = 0;

  vram_cmd_sequencer #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk),
    .i_reset_n(rst_n),
    .i_instruction(instr),
    .i_instruction_ready(ready),
    .i_disp_req(disp),
    .o_busy(o_busy),
    .o_idle(o_idle),
    .o_overflow(o_overflow),
    .o_illegal(o_illegal),
    .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr),
    .o_mem_data(o_mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: instruction queue, engine phase and pixels still owed.
  logic [31:0]       mq [$];
  int                m_stage;
  int                m_pix;
  logic [31:0]       m_cmd;
  logic [ADDR_W-1:0] m_addr;
  logic              m_we, m_ovf, m_ill, m_prev_disp, m_full;
  logic [ADDR_W-1:0] m_maddr;
  logic [7:0]        m_mdata;
  int                cyc = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_stage = M_READY; m_pix = 0; m_cmd = '0; m_addr = '0;
      m_we = 1'b0; m_ovf = 1'b0; m_ill = 1'b0; m_prev_disp = 1'b0;
      m_maddr = '0; m_mdata = '0;
    end else begin
      cyc++;
      m_we = 1'b0; m_ovf = 1'b0; m_ill = 1'b0;
      m_full = (mq.size() == DEPTH);
      case (m_stage)
        M_READY: if (mq.size() != 0) begin
          m_cmd = mq.pop_front();
          m_stage = M_DECODE;
        end
        M_DECODE: begin
          m_stage = M_READY;
          case (m_cmd[31:28])
            4'h0: ;
            4'h1: m_addr = m_cmd[ADDR_W-1:0];
            4'h2: begin m_pix = 1; m_stage = M_PIXELS; end
`ifdef VRAM_FILL_EN
            4'h3: begin m_pix = int'(m_cmd[23:8]) + 1; m_stage = M_PIXELS; end
`endif
            default: m_ill = 1'b1;
          endcase
        end
        default: if (!disp) begin
          m_we = 1'b1;
          m_maddr = m_addr;
          m_mdata = m_cmd[7:0];
          m_addr = ADDR_W'(m_addr + 1);
          m_pix--;
          if (m_pix == 0) m_stage = M_READY;
        end
      endcase
      if (ready) begin
        if (m_full) m_ovf = 1'b1;
        else        mq.push_back(instr);
      end
      m_prev_disp = disp;
    end
  end

  typedef struct { int c; logic [ADDR_W-1:0] a; logic [7:0] d; } wr_t;
  wr_t wlog [$];
  int  ill_cnt = 0;
  int  ovf_cnt = 0;
  logic busy_seen = 1'b0;

  // Per-cycle comparison against the model, plus logging for directed checks.
  always @(negedge clk) begin
    if (rst_n) begin
      logic [ADDR_W+12:0] exp_v, act_v;
      exp_v = {m_we, m_maddr, m_mdata, (mq.size() == DEPTH),
               (m_stage == M_READY && mq.size() == 0), m_ovf, m_ill};
      act_v = {o_mem_we, o_mem_addr, o_mem_data, o_busy, o_idle, o_overflow, o_illegal};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL model cyc=%0d: got we=%b addr=%h data=%h busy=%b idle=%b ovf=%b ill=%b, expected we=%b addr=%h data=%h busy=%b idle=%b ovf=%b ill=%b",
                 cyc, o_mem_we, o_mem_addr, o_mem_data, o_busy, o_idle, o_overflow, o_illegal,
                 exp_v[ADDR_W+12], exp_v[ADDR_W+11:12], exp_v[11:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
      end
      checks++;
      if (m_prev_disp && o_mem_we) begin
        errors++;
        $display("FAIL disp_write cyc=%0d: got we=1 after disp_req edge, expected 0", cyc);
      end
      if (o_mem_we) wlog.push_back('{c: cyc, a: o_mem_addr, d: o_mem_data});
      if (o_illegal) ill_cnt++;
      if (o_overflow) ovf_cnt++;
      if (o_busy) busy_seen = 1'b1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push1(input logic [31:0] w, output int c0);
    @(negedge clk);
    instr = w; ready = 1'b1; c0 = cyc + 1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    ready = 1'b0; disp = 1'b0;
    while (!(m_stage == M_READY && mq.size() == 0) && n < 2000) begin
      @(negedge clk); n++;
    end
    if (n >= 2000) begin
      errors++;
      $display("FAIL drain_timeout: got busy after %0d cycles, expected idle", n);
    end
    repeat (3) @(negedge clk);
  endtask

  int c0, ill0, ovf0, n, r;
  logic [31:0] w;

  initial begin
    rst_n = 1'b0; ready = 1'b0; disp = 1'b0; instr = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", o_busy, 0);
    chk("rst_idle", o_idle, 1);
    chk("rst_we", o_mem_we, 0);
    chk("rst_addr", o_mem_addr, 0);
    chk("rst_data", o_mem_data, 0);
    chk("rst_ovf", o_overflow, 0);
    chk("rst_ill", o_illegal, 0);
    rst_n = 1'b1;

    // SET_ADDR then single WRITE with idle engine.
    push1(32'h1000_0010, c0); drain();
    wlog.delete();
    push1(32'h2000_00AB, c0); drain();
    chk("wr_count", wlog.size(), 1);
    if (wlog.size() >= 1) begin
      chk("wr_cycle", wlog[0].c, c0 + 3);
      chk("wr_addr", int'(wlog[0].a), 32'h10);
      chk("wr_data", int'(wlog[0].d), 32'hAB);
    end
    chk("wr_idle", o_idle, 1);

    // FILL across the top of the address space.
    push1(32'h1000_7FFE, c0); drain();
    wlog.delete(); ill0 = ill_cnt;
    push1(32'h3000_0355, c0); drain();
`ifdef VRAM_FILL_EN
    chk("fill_count", wlog.size(), 4);
    if (wlog.size() == 4) begin
      chk("fill_first", wlog[0].c, c0 + 3);
      for (int i = 0; i < 4; i++) begin
        chk("fill_addr", int'(wlog[i].a), (32'h7FFE + i) & 32'h7FFF);
        chk("fill_data", int'(wlog[i].d), 32'h55);
        chk("fill_cyc", wlog[i].c, wlog[0].c + i);
      end
    end
`else
    chk("fill_disabled_writes", wlog.size(), 0);
    chk("fill_disabled_ill", ill_cnt - ill0, 1);
`endif

    // FILL of 8 with three display-stall cycles.
    wlog.delete(); ill0 = ill_cnt;
    for (int k = 0; k < 21; k++) begin
      @(negedge clk);
      ready = (k == 0);
      instr = 32'h3000_073C;
      disp  = (k == 4 || k == 6 || k == 9);
      if (k == 0) c0 = cyc + 1;
    end
    drain();
`ifdef VRAM_FILL_EN
    chk("stall_count", wlog.size(), 8);
    if (wlog.size() == 8) begin
      chk("stall_first", wlog[0].c, c0 + 3);
      chk("stall_span", wlog[7].c - wlog[0].c + 1, 11);
      n = 0;
      for (int i = 0; i < 8; i++) begin
        if (wlog[i].c == c0 + 4 || wlog[i].c == c0 + 6 || wlog[i].c == c0 + 9) n++;
        chk("stall_addr", int'(wlog[i].a), int'(ADDR_W'(wlog[0].a + ADDR_W'(i))));
      end
      chk("stall_in_bubble", n, 0);
    end
`else
    chk("stall_disabled_writes", wlog.size(), 0);
    chk("stall_disabled_ill", ill_cnt - ill0, 1);
`endif

    // Overflow with scanout holding the port.
    wlog.delete(); ovf0 = ovf_cnt; busy_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      disp = 1'b1; ready = 1'b1; instr = 32'h2000_0010 + 32'(i);
    end
    @(negedge clk); ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("ovf_busy_seen", busy_seen, 1);
    chk("ovf_busy_now", o_busy, 1);
    chk("ovf_pulses", ovf_cnt - ovf0, 1);
    chk("ovf_no_write", wlog.size(), 0);
    drain();
    chk("ovf_writes", wlog.size(), 5);
    if (wlog.size() == 5)
      for (int i = 0; i < 5; i++) chk("ovf_data", int'(wlog[i].d), 32'h10 + i);

    // Unknown opcode.
    wlog.delete(); ill0 = ill_cnt;
    push1(32'h7000_0000, c0); drain();
    chk("ill_pulse", ill_cnt - ill0, 1);
    chk("ill_no_write", wlog.size(), 0);

    // Asynchronous reset in the middle of an operation.
    wlog.delete();
`ifdef VRAM_FILL_EN
    push1(32'h3000_6377, c0);
    n = 0;
    while (wlog.size() < 10 && n < 200) begin @(negedge clk); n++; end
    chk("rst_mid_reached", int'(wlog.size() >= 10), 1);
`else
    disp = 1'b1;
    for (int i = 0; i < 3; i++) push1(32'h2000_0077, c0);
    repeat (2) @(negedge clk);
`endif
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_we", o_mem_we, 0);
    chk("rst_mid_idle", o_idle, 1);
    chk("rst_mid_busy", o_busy, 0);
    chk("rst_mid_addr", o_mem_addr, 0);
    @(negedge clk); disp = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    wlog.delete();
    push1(32'h2000_005A, c0); drain();
    chk("post_rst_count", wlog.size(), 1);
    if (wlog.size() == 1) begin
      chk("post_rst_addr", int'(wlog[0].a), 0);
      chk("post_rst_data", int'(wlog[0].d), 32'h5A);
    end

    // Randomized traffic checked cycle by cycle against the model.
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      r = int'($urandom_range(0, 9));
      case (r)
        0: w = 32'h0000_0000 | 32'($urandom_range(0, 255));
        1, 2: w = {4'h1, 13'h0, 15'($urandom)};
        3, 4, 5: w = {4'h2, 20'($urandom), 8'($urandom)};
        6, 7: w = {4'h3, 8'($urandom), 8'($urandom_range(0, 6)), 8'($urandom)};
        8: w = {4'h7, 28'($urandom)};
        default: w = {4'($urandom_range(4, 15)), 28'($urandom)};
      endcase
      instr = w;
      ready = ($urandom_range(0, 2) == 0);
      disp  = ($urandom_range(0, 3) == 0);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
